// File: rtl/excitation_detector.sv
// excitation_detector
// Qualifies the asynchronous envelope-comparator output, skips the packet
// preamble, then opens a bounded trigger window for the square-wave shift
// generator. The window ends on timeout or carrier dropout, and a hold-off
// period follows before the detector re-arms.
module excitation_detector #(
  parameter int CW             = 16,
  parameter int MIN_HIGH       = 32,
  parameter int DELAY_CYCLES   = 1024,
  parameter int ACTIVE_CYCLES  = 20480,
  parameter int DROP_CYCLES    = 64,
  parameter int HOLDOFF_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic env_in,
  output logic trigger_signal,
  output logic done_pulse,
  output logic drop_flag,
  output logic busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_DELAY   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  // Terminal counts, sized to the counter width.
  localparam logic [CW-1:0] L_QUAL_LAST = CW'(MIN_HIGH - 1);
  localparam logic [CW-1:0] L_DLY_LAST  = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] L_ACT_LAST  = CW'(ACTIVE_CYCLES - 1);
  localparam logic [CW-1:0] L_DROP_LAST = CW'(DROP_CYCLES - 1);
  localparam logic [CW-1:0] L_HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0] L_ZERO      = '0;
  localparam logic [CW-1:0] L_ONE       = CW'(1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic [CW-1:0] r_low_cnt;
  logic [CW-1:0] w_next_low_cnt;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_trigger;
  logic          r_done;
  logic          r_drop;
  logic          r_busy;
  logic          w_done_next;
  logic          w_drop_next;
  logic          w_env_s;
  logic          w_dropout;
  logic          w_timeout;

  assign w_env_s   = r_sync2;
  assign w_dropout = (w_env_s == 1'b0) && (r_low_cnt == L_DROP_LAST);
  assign w_timeout = (r_cnt == L_ACT_LAST);

  // Two-flop synchronizer bringing the comparator output into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= env_in;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counter and window-end decode.
  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_next_low_cnt = r_low_cnt;
    w_done_next    = 1'b0;
    w_drop_next    = r_drop;
    if (!enable) begin
      w_next_state   = ST_IDLE;
      w_next_cnt     = L_ZERO;
      w_next_low_cnt = L_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_env_s) begin
            w_next_state = ST_QUALIFY;
            w_next_cnt   = L_ONE;
          end else begin
            w_next_cnt   = L_ZERO;
          end
        end
        ST_QUALIFY: begin
          if (!w_env_s) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = L_ZERO;
          end else if (r_cnt == L_QUAL_LAST) begin
            w_next_state = ST_DELAY;
            w_next_cnt   = L_ZERO;
          end else begin
            w_next_cnt   = r_cnt + L_ONE;
          end
        end
        ST_DELAY: begin
          if (!w_env_s) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = L_ZERO;
          end else if (r_cnt == L_DLY_LAST) begin
            w_next_state   = ST_ACTIVE;
            w_next_cnt     = L_ZERO;
            w_next_low_cnt = L_ZERO;
          end else begin
            w_next_cnt     = r_cnt + L_ONE;
          end
        end
        ST_ACTIVE: begin
          // Dropout takes priority over timeout when both land together.
          if (w_dropout) begin
            w_next_state   = ST_HOLDOFF;
            w_next_cnt     = L_ZERO;
            w_next_low_cnt = L_ZERO;
            w_done_next    = 1'b1;
            w_drop_next    = 1'b1;
          end else if (w_timeout) begin
            w_next_state   = ST_HOLDOFF;
            w_next_cnt     = L_ZERO;
            w_next_low_cnt = L_ZERO;
            w_done_next    = 1'b1;
            w_drop_next    = 1'b0;
          end else begin
            w_next_cnt     = r_cnt + L_ONE;
            w_next_low_cnt = w_env_s ? L_ZERO : (r_low_cnt + L_ONE);
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt == L_HOLD_LAST) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = L_ZERO;
          end else begin
            w_next_cnt   = r_cnt + L_ONE;
          end
        end
        default: begin
          w_next_state   = ST_IDLE;
          w_next_cnt     = L_ZERO;
          w_next_low_cnt = L_ZERO;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they line up with the state register in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= L_ZERO;
      r_low_cnt <= L_ZERO;
      r_trigger <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_low_cnt <= w_next_low_cnt;
      r_trigger <= (w_next_state == ST_ACTIVE);
      r_done    <= w_done_next;
      r_drop    <= w_drop_next;
      r_busy    <= (w_next_state != ST_IDLE);
    end
  end

  assign trigger_signal = r_trigger;
  assign done_pulse     = r_done;
  assign drop_flag      = r_drop;
  assign busy           = r_busy;

endmodule
